dfe_output_formatter: RTL and testbench
=======================================

# dfe_output_formatter

Output stage directly downstream of the CIC third-stage top. Consumes the 28-bit sfix28_En15 decimated/compensated stream (`y_out`/`y_valid`), applies a programmable rounding right-shift to remove CIC gain growth, and saturates to 16-bit sfix16_En15. Results are buffered in a small FIFO with a valid/ready handshake toward the downstream consumer, and the block reports saturation and drop statistics.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of the saturating statistics counters.

- `clk`  in  1  clock; all state is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clk_enable`  in  1  global enable; when low, all state holds.
- `sync_reset`  in  1  synchronous clear, same effect as reset (gated by `clk_enable`).
- `in_sample`  in  28  signed, sfix28_En15, from CIC top `y_out`.
- `in_valid`  in  1  sample qualifier, from `y_valid`.
- `gain_shift`  in  4  right-shift amount, 0..12; values >12 clamp to 12. Sampled with each valid sample.
- `out_data`  out  16  signed, sfix16_En15, FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy.
- `sat_flag`  out  1  sticky; set when any sample saturated.
- `sat_count`  out  CNT_W  saturated samples; saturates at all-ones.
- `drop_count`  out  CNT_W  samples lost to a full FIFO; saturates at all-ones.

## Operation
- **Stage 1 (round/saturate, registered).** On `clk_enable & in_valid`:
  - Let s = min(`gain_shift`, 12).
  - Compute t = sign-extend(`in_sample`) to 29 bits + (s>0 ? 2^(s-1) : 0). This is round-half-up.
  - Compute r = t >>> s (arithmetic shift).
  - If r > 32767, output 32767. If r < −32768, output −32768. Otherwise output r[15:0].
  - On saturation, set `sat_flag` and increment `sat_count`.
  - Register the result and assert the internal `s1_vld` for one enabled cycle.
- **Stage 2 (FIFO).** Circular buffer with `DEPTH` entries, a read pointer, a write pointer and a level counter.
  - Push when `s1_vld`. Pop when `out_valid & out_ready & clk_enable`.
  - Push into a full FIFO with no simultaneous pop: discard the sample and increment `drop_count`. Stored entries are untouched.
  - Push into a full FIFO with a simultaneous pop: accept the push. Level stays at DEPTH.
  - Pop and push on an empty FIFO: no pop occurs, because `out_valid` is 0. The push is accepted and level becomes 1.
  - Pointers wrap modulo DEPTH.
- **Output.** `out_data` is the head entry (first-word fall-through) and is stable while `out_valid & !out_ready`. Order is strict FIFO.
- **Clock enable low.** All registers hold. `out_ready` is ignored and no pop occurs. `out_valid` and `out_data` hold.
- **Reset (async `reset_n` low, or `sync_reset` on an enabled edge).** Clears pointers, level, `s1_vld`, `sat_flag`, `sat_count` and `drop_count`. Any sample in flight is discarded. Reset mid-transfer drops all FIFO contents without any partial output.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `fifo_level`=0, `sat_flag`=0, `sat_count`=0, `drop_count`=0.
- Latency from sample to output:
  - Sample accepted at edge N is registered in stage 1 at N.
  - It is written to the FIFO at edge N+1 (all edges counted as enabled edges).
  - With an empty FIFO, `out_valid`=1 and `out_data`=result in the cycle after edge N+1. Total latency is 2 enabled cycles.
- Throughput: one sample per cycle sustained when `out_ready`=1.
- `fifo_level` updates on the same edge as the push/pop: +1 for push only, −1 for pop only, unchanged for both.
- Counters and `sat_flag` update on the edge that registers the stage-1 result. `drop_count` updates on the edge of the rejected push.
- `out_ready` has no combinational path to any output except through registered state.

## Test plan
- **Pass-through.** `gain_shift`=0; `in_sample`=0x0001234, then 0xFFFEDCC; `out_ready`=1 → `out_data`=0x1234, then 0xEDCC, each 2 cycles after its input; `sat_flag`=0.
- **Rounding.** `gain_shift`=4; inputs 1000, 1007, −1000, −1009 → outputs 63, 63, −62, −63. `gain_shift`=15 with input 8192 → 2, confirming the clamp to 12.
- **Saturation.** `gain_shift`=0; inputs 40000, −40000, 32767 → outputs 32767, −32768, 32767; `sat_count`=2; `sat_flag` remains 1 after further clean samples.
- **Full/drop.** DEPTH=8; `out_ready`=0; 10 consecutive valid samples 1..10 → `fifo_level`=8, `drop_count`=2. Then `out_ready`=1 → outputs 1..8 in order, and `out_valid` falls after 8 pops.
- **Simultaneous push/pop at full.** FIFO full; `out_ready`=1 while pushing a sample each cycle → no drops, level stays 8, order preserved. Also hold `clk_enable`=0 for 3 cycles → no state change, `out_data` held.
- **Reset mid-operation.** FIFO holding 5 entries, counters nonzero; pulse `sync_reset` → next cycle `out_valid`=0, level=0, all counters 0. Repeat with `reset_n` asserted asynchronously between edges → outputs clear immediately, without waiting for an edge.

Source files
------------

// File: rtl/dfe_output_formatter.sv
// Output stage after the CIC top: rounding right-shift, saturation to sfix16_En15,
// and a first-word fall-through FIFO with saturation and drop statistics.
module dfe_output_formatter #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clk_enable,
    input  logic                     sync_reset,
    input  logic [27:0]              in_sample,
    input  logic                     in_valid,
    input  logic [3:0]               gain_shift,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     sat_flag,
    output logic [CNT_W-1:0]         sat_count,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [3:0]          shift_amt;
    logic signed [28:0]  round_add;
    logic signed [28:0]  t_sum;
    logic signed [28:0]  r_shift;
    logic                sat_hi;
    logic                sat_lo;
    logic [15:0]         res_d;

    logic                s1_vld_q;
    logic [15:0]         s1_data_q;
    logic                sat_flag_q;
    logic [CNT_W-1:0]    sat_count_q;
    logic [CNT_W-1:0]    drop_count_q;

    logic [15:0]         mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [LW-1:0]       level_q;
    logic [LW-1:0]       level_d;

    logic                full;
    logic                pop;
    logic                push_ok;
    logic                drop;

    always_comb begin
        shift_amt = (gain_shift > 4'd12) ? 4'd12 : gain_shift;
        round_add = '0;
        if (shift_amt != 4'd0) begin
            round_add = 29'sd1 <<< (shift_amt - 4'd1);
        end
        t_sum   = $signed({in_sample[27], in_sample}) + round_add;
        r_shift = t_sum >>> shift_amt;
        sat_hi  = (r_shift > 29'sd32767);
        sat_lo  = (r_shift < -29'sd32768);
        if (sat_hi) begin
            res_d = 16'h7fff;
        end else if (sat_lo) begin
            res_d = 16'h8000;
        end else begin
            res_d = r_shift[15:0];
        end
    end

    assign full    = (level_q == LW'(DEPTH));
    assign pop     = (level_q != '0) && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok = s1_vld_q && (!full || pop);
    assign drop    = s1_vld_q && full && !pop;

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q     <= 1'b0;
            s1_data_q    <= '0;
            sat_flag_q   <= 1'b0;
            sat_count_q  <= '0;
            drop_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
        end else if (clk_enable) begin
            if (sync_reset) begin
                s1_vld_q     <= 1'b0;
                s1_data_q    <= '0;
                sat_flag_q   <= 1'b0;
                sat_count_q  <= '0;
                drop_count_q <= '0;
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                level_q      <= '0;
            end else begin
                s1_vld_q <= in_valid;
                if (in_valid) begin
                    s1_data_q <= res_d;
                    if (sat_hi || sat_lo) begin
                        sat_flag_q <= 1'b1;
                        if (!(&sat_count_q)) begin
                            sat_count_q <= sat_count_q + CNT_W'(1);
                        end
                    end
                end
                if (drop && !(&drop_count_q)) begin
                    drop_count_q <= drop_count_q + CNT_W'(1);
                end
                if (push_ok) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                level_q <= level_d;
            end
        end
    end

    // Storage needs no reset: entries are only visible while the level covers them.
    always_ff @(posedge clk) begin
        if (clk_enable && !sync_reset && push_ok) begin
            mem_q[wr_ptr_q] <= s1_data_q;
        end
    end

    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign fifo_level = level_q;
    assign sat_flag   = sat_flag_q;
    assign sat_count  = sat_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_dfe_output_formatter.sv
// Bench for dfe_output_formatter: vector table, hand-written FIFO/reset sequences
// and a randomized run against a queue-based reference model.
module tb_dfe_output_formatter;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_enable = 1'b1;
    logic        sync_reset = 1'b0;
    logic [27:0] in_sample = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  gain_shift = '0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [$clog2(DEPTH):0] fifo_level;
    logic        sat_flag;
    logic [CNT_W-1:0] sat_count;
    logic [CNT_W-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    dfe_output_formatter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .sync_reset(sync_reset),
        .in_sample(in_sample), .in_valid(in_valid), .gain_shift(gain_shift),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .sat_flag(sat_flag), .sat_count(sat_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  g;
        logic [27:0] x;
        longint      y;
        bit          sat;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; sync_reset = 1'b0; clk_enable = 1'b1;
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        step();
    endtask

    function automatic longint dout();
        return longint'($signed(out_data));
    endfunction

    // Reference: floor((x + half) / 2^s) followed by clamping to the 16-bit range.
    function automatic void ref_fmt(input logic [27:0] x, input logic [3:0] g,
                                    output longint y, output bit sat);
        longint xs, d, v, r;
        int s;
        xs = longint'($signed(x));
        s  = (g > 12) ? 12 : int'(g);
        d  = longint'(1) << s;
        v  = xs + ((s > 0) ? d / 2 : 0);
        if (v >= 0) r = v / d;
        else        r = -((-v + d - 1) / d);
        sat = 1'b0;
        y = r;
        if (r > 32767)  begin y = 32767;  sat = 1'b1; end
        if (r < -32768) begin y = -32768; sat = 1'b1; end
    endfunction

    task automatic fill_mid();
        do_reset();
        gain_shift = 4'd0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_sample = 28'd40000;
            step();
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        check("mid_level", fifo_level, 5);
        check("mid_drop", drop_count, 2);
        check("mid_sat", sat_count, 10);
    endtask

    // Randomized-run model state
    longint mq[$];
    bit     m_s1_vld;
    longint m_s1_data;
    int     m_sat_cnt, m_drop_cnt;
    bit     m_sat_flag;

    initial begin
        int exp_sat;
        longint exp_head;

        vecs[0]  = '{4'd0,  28'h0001234,   longint'(16'sh1234), 1'b0};
        vecs[1]  = '{4'd0,  28'hFFFEDCC,   -4660,  1'b0};
        vecs[2]  = '{4'd4,  28'd1000,      63,     1'b0};
        vecs[3]  = '{4'd4,  28'd1007,      63,     1'b0};
        vecs[4]  = '{4'd4,  28'(-1000),    -62,    1'b0};
        vecs[5]  = '{4'd4,  28'(-1009),    -63,    1'b0};
        vecs[6]  = '{4'd15, 28'd8192,      2,      1'b0};
        vecs[7]  = '{4'd0,  28'd40000,     32767,  1'b1};
        vecs[8]  = '{4'd0,  28'(-40000),   -32768, 1'b1};
        vecs[9]  = '{4'd0,  28'd32767,     32767,  1'b0};
        vecs[10] = '{4'd1,  28'(-3),       -1,     1'b0};
        vecs[11] = '{4'd0,  28'(-32768),   -32768, 1'b0};

        #2;
        check("rst_valid", out_valid, 0);
        check("rst_data", dout(), 0);
        check("rst_level", fifo_level, 0);
        check("rst_satflag", sat_flag, 0);
        check("rst_satcnt", sat_count, 0);
        check("rst_dropcnt", drop_count, 0);

        // Vector table: one sample at a time, 2-cycle latency into an empty FIFO
        do_reset();
        exp_sat = 0;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; in_sample = vecs[i].x; gain_shift = vecs[i].g;
            step();
            in_valid = 1'b0;
            check("vec_lat1", out_valid, 0);
            step();
            if (vecs[i].sat) exp_sat++;
            check("vec_valid", out_valid, 1);
            check("vec_data", dout(), vecs[i].y);
            check("vec_satcnt", sat_count, exp_sat);
            check("vec_satflag", sat_flag, (exp_sat > 0) ? 1 : 0);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check("vec_empty", out_valid, 0);
        end

        // Full / drop
        do_reset();
        gain_shift = 4'd0;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1; in_sample = 28'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        check("full_level", fifo_level, 8);
        check("full_drop", drop_count, 2);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check("drain_valid", out_valid, 1);
            check("drain_data", dout(), k);
            step();
        end
        check("drain_empty", out_valid, 0);
        out_ready = 1'b0;

        // Simultaneous push/pop at full, then clock-enable hold
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1; in_sample = 28'(i);
            step();
        end
        check("pp_full", fifo_level, 8);
        out_ready = 1'b1;
        exp_head = 1;
        for (int k = 0; k < 6; k++) begin
            check("pp_data", dout(), exp_head);
            in_sample = 28'(10 + k);
            step();
            exp_head++;
            check("pp_level", fifo_level, 8);
            check("pp_drop", drop_count, 0);
        end
        clk_enable = 1'b0; in_sample = 28'd99;
        repeat (3) begin
            step();
            check("hold_data", dout(), 7);
            check("hold_level", fifo_level, 8);
            check("hold_valid", out_valid, 1);
        end
        clk_enable = 1'b1; in_valid = 1'b0;
        step();
        check("resume_data", dout(), 8);
        check("resume_level", fifo_level, 8);
        check("resume_drop", drop_count, 0);
        out_ready = 1'b0;

        // Synchronous reset mid-operation with a sample in flight
        fill_mid();
        in_valid = 1'b1; in_sample = 28'd5; sync_reset = 1'b1;
        step();
        sync_reset = 1'b0; in_valid = 1'b0;
        check("srst_valid", out_valid, 0);
        check("srst_level", fifo_level, 0);
        check("srst_sat", sat_count, 0);
        check("srst_drop", drop_count, 0);
        check("srst_flag", sat_flag, 0);
        check("srst_data", dout(), 0);
        step();
        check("srst_inflight", out_valid, 0);

        // Asynchronous reset between edges
        fill_mid();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_level", fifo_level, 0);
        check("arst_sat", sat_count, 0);
        check("arst_drop", drop_count, 0);
        check("arst_flag", sat_flag, 0);
        reset_n = 1'b1;
        step();
        check("arst_after", out_valid, 0);

        // Randomized run against the queue model
        do_reset();
        mq.delete();
        m_s1_vld = 0; m_s1_data = 0; m_sat_cnt = 0; m_drop_cnt = 0; m_sat_flag = 0;
        for (int c = 0; c < 2000; c++) begin
            bit pop;
            longint y;
            bit sat;
            clk_enable = ($urandom_range(0, 9) != 0);
            sync_reset = ($urandom_range(0, 249) == 0);
            in_valid   = ($urandom_range(0, 2) != 0);
            out_ready  = $urandom_range(0, 1);
            gain_shift = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) != 0) in_sample = 28'($urandom);
            else in_sample = 28'(int'($urandom_range(0, 400000)) - 200000);
            if (clk_enable) begin
                if (sync_reset) begin
                    mq.delete();
                    m_s1_vld = 0; m_sat_cnt = 0; m_drop_cnt = 0; m_sat_flag = 0;
                end else begin
                    pop = (mq.size() > 0) && out_ready;
                    if (pop) void'(mq.pop_front());
                    if (m_s1_vld) begin
                        if (mq.size() == DEPTH) m_drop_cnt = (m_drop_cnt < CMAX) ? m_drop_cnt + 1 : CMAX;
                        else mq.push_back(m_s1_data);
                    end
                    m_s1_vld = in_valid;
                    if (in_valid) begin
                        ref_fmt(in_sample, gain_shift, y, sat);
                        m_s1_data = y;
                        if (sat) begin
                            m_sat_flag = 1;
                            m_sat_cnt = (m_sat_cnt < CMAX) ? m_sat_cnt + 1 : CMAX;
                        end
                    end
                end
            end
            step();
            check("rnd_valid", out_valid, (mq.size() > 0) ? 1 : 0);
            check("rnd_data", dout(), (mq.size() > 0) ? mq[0] : 0);
            check("rnd_level", fifo_level, mq.size());
            check("rnd_satflag", sat_flag, m_sat_flag);
            check("rnd_satcnt", sat_count, m_sat_cnt);
            check("rnd_dropcnt", drop_count, m_drop_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
